// File: rtl/y86_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : y86_imem_loader
// Purpose  : Takes decoded Y86-64 instructions over a valid/ready handshake
//            and writes their fetch-order byte encoding, one byte per cycle,
//            into a byte-wide instruction memory at an auto-incrementing
//            address.
// Revision : 1.0  initial release
// ============================================================================
module y86_imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [15:0]       instr_count,
  output logic              busy,
  output logic              err_invalid,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EMIT_OP   = 2'd1,
    S_EMIT_REG  = 2'd2,
    S_EMIT_VALC = 2'd3
  } state_t;

  // Encoded length in bytes; 0 marks an unsupported icode.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h7, 4'h8:             return 4'd9;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      default:                return 4'd0;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    return (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
  endfunction

  function automatic logic has_valc(input logic [3:0] ic);
    return (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic [2:0]        idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]       count_q, count_d;
  logic              err_inv_q, err_inv_d;
  logic              err_ovf_q, err_ovf_d;

  logic              w_accept;
  logic [ADDR_W:0]   w_end;
  logic              w_emit;
  logic [7:0]        w_byte;
  logic [2:0]        w_next_idx;

  assign in_ready     = (state_q == S_IDLE) && !err_ovf_q && !base_load;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wr_ptr       = wr_ptr_q;
  assign instr_count  = count_q;
  assign busy         = (state_q != S_IDLE);
  assign err_invalid  = err_inv_q;
  assign err_overflow = err_ovf_q;

  // Next-state, byte selection and write-strobe generation.
  always_comb begin
    state_d     = state_q;
    icode_d     = icode_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    valc_d      = valc_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_inv_d   = err_inv_q;
    err_ovf_d   = err_ovf_q;
    w_emit      = 1'b0;
    w_byte      = 8'h00;
    w_accept    = in_valid && in_ready;
    w_end       = {1'b0, wr_ptr_q} + (ADDR_W+1)'(instr_len(in_icode));
    w_next_idx  = idx_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (base_load) begin
          wr_ptr_d  = base_addr;
          err_ovf_d = 1'b0;
        end else if (w_accept) begin
          if (in_icode > 4'hB) begin
            err_inv_d = 1'b1;
          end else if (w_end > c_DEPTH) begin
            err_ovf_d = 1'b1;
          end else begin
            icode_d = in_icode;
            ra_d    = in_rA;
            rb_d    = in_rB;
            valc_d  = in_valC;
            w_emit  = 1'b1;
            w_byte  = {in_icode, in_ifun};
            state_d = S_EMIT_OP;
          end
        end
      end
      S_EMIT_OP: begin
        if (has_reg(icode_q)) begin
          w_emit  = 1'b1;
          w_byte  = {ra_q, rb_q};
          state_d = S_EMIT_REG;
        end else if (has_valc(icode_q)) begin
          w_emit  = 1'b1;
          w_byte  = valc_q[7:0];
          idx_d   = 3'd0;
          state_d = S_EMIT_VALC;
        end else begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      S_EMIT_REG: begin
        if (has_valc(icode_q)) begin
          w_emit  = 1'b1;
          w_byte  = valc_q[7:0];
          idx_d   = 3'd0;
          state_d = S_EMIT_VALC;
        end else begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      S_EMIT_VALC: begin
        if (idx_q == 3'd7) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          w_emit  = 1'b1;
          w_byte  = valc_q[{w_next_idx, 3'b000} +: 8];
          idx_d   = w_next_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Each presented byte goes to the current pointer, which then advances.
    if (w_emit) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_ptr_q;
      mem_wdata_d = w_byte;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
    end
  end

  // State and registered outputs; reset aborts any emission in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      icode_q     <= 4'h0;
      ra_q        <= 4'h0;
      rb_q        <= 4'h0;
      valc_q      <= 64'h0;
      idx_q       <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      wr_ptr_q    <= '0;
      count_q     <= 16'd0;
      err_inv_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      icode_q     <= icode_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      valc_q      <= valc_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_inv_q   <= err_inv_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

endmodule
`default_nettype wire
